// File: rtl/cpu_defs.sv
// Shared definitions for the execute-stage multi-cycle HI/LO unit.
//   oper_t          : HI/LO-writing operation codes (OP_NOP marks "anything else")
//   multicyc_req_t  : EX -> unit request {op, reg0, reg1, is_multicyc, hilo}
//   multicyc_resp_t : unit -> EX response {ready, hilo}
//   muldiv_state_t  : control FSM states of multicyc_muldiv
package cpu_defs;

  typedef enum logic [3:0] {
    OP_MULT  = 4'd0,
    OP_MULTU = 4'd1,
    OP_MADD  = 4'd2,
    OP_MADDU = 4'd3,
    OP_MSUB  = 4'd4,
    OP_MSUBU = 4'd5,
    OP_DIV   = 4'd6,
    OP_DIVU  = 4'd7,
    OP_MTHI  = 4'd8,
    OP_MTLO  = 4'd9,
    OP_NOP   = 4'd15
  } oper_t;

  typedef struct packed {
    oper_t       op;
    logic [31:0] reg0;
    logic [31:0] reg1;
    logic        is_multicyc;
    logic [63:0] hilo;
  } multicyc_req_t;

  typedef struct packed {
    logic        ready;
    logic [63:0] hilo;
  } multicyc_resp_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } muldiv_state_t;

  // Two's-complement magnitude; unsigned operands pass through untouched.
  function automatic logic [31:0] magnitude(input logic [31:0] x, input logic is_signed);
    return (is_signed && x[31]) ? -x : x;
  endfunction

endpackage

// File: rtl/multicyc_div.sv
// Iterative radix-2 restoring divider, one quotient bit per cycle.
//   clk, rst (async, active-low), start (load operands and begin),
//   is_signed, dividend, divisor (sampled on start).
//   done       : high in the final iteration cycle
//   quotient   : sign-corrected quotient, valid while done
//   remainder  : sign-corrected remainder (dividend's sign), valid while done
module multicyc_div
  import cpu_defs::*;
#(
  parameter int DIV_BITS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  localparam int CNT_W = $clog2(DIV_BITS);

  logic             busy;
  logic [CNT_W-1:0] count_q;
  logic [31:0]      rem_q;
  logic [31:0]      quo_q;
  logic [31:0]      dvs_q;
  logic             neg_quot_q;
  logic             neg_rem_q;

  logic [32:0]      partial;
  logic             fits;
  logic [31:0]      rem_n;
  logic [31:0]      quo_n;

  // quo_q starts as the dividend magnitude; its MSB is shifted into the
  // partial remainder while the new quotient bit enters at the bottom.
  always_comb begin
    partial = {rem_q, quo_q[31]};
    fits    = partial >= {1'b0, dvs_q};
    rem_n   = fits ? 32'(partial - {1'b0, dvs_q}) : partial[31:0];
    quo_n   = {quo_q[30:0], fits};
  end

  // The result is taken straight from the last step so the controller can
  // capture it on the same edge that finishes the iteration.
  always_comb begin
    done      = busy && (count_q == '0);
    quotient  = neg_quot_q ? -quo_n : quo_n;
    remainder = neg_rem_q  ? -rem_n : rem_n;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy       <= 1'b0;
      count_q    <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
    end else if (start) begin
      busy       <= 1'b1;
      count_q    <= CNT_W'(DIV_BITS - 1);
      rem_q      <= '0;
      quo_q      <= magnitude(dividend, is_signed);
      dvs_q      <= magnitude(divisor, is_signed);
      neg_quot_q <= is_signed && (dividend[31] ^ divisor[31]);
      neg_rem_q  <= is_signed && dividend[31];
    end else if (busy) begin
      rem_q <= rem_n;
      quo_q <= quo_n;
      if (count_q == '0) begin
        busy <= 1'b0;
      end else begin
        count_q <= count_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/multicyc_muldiv.sv
// Multi-cycle HI/LO unit of the execute stage (responder of multicyc_req/resp).
//   clk, rst (async, active-low)
//   multicyc_req  : operation request from EX, sampled in IDLE
//   flush         : synchronous abort of any in-flight operation
//   multicyc_resp : one-cycle ready pulse with the new {HI,LO}
module multicyc_muldiv
  import cpu_defs::*;
#(
  parameter int MUL_CYCLES = 2,
  parameter int DIV_BITS   = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  multicyc_req_t  multicyc_req,
  input  logic           flush,
  output multicyc_resp_t multicyc_resp
);

  localparam logic [1:0] MUL_LOAD = 2'(MUL_CYCLES - 1);

  muldiv_state_t state_q, state_d;
  logic [1:0]    count_q, count_d;
  logic [63:0]   result_q, result_d;
  logic          accept;
  logic          div_start;

  oper_t         op_q;
  logic [31:0]   a_q;
  logic [31:0]   b_q;
  logic [63:0]   hilo_q;

  logic          mul_signed;
  logic [63:0]   a_ext;
  logic [63:0]   b_ext;
  logic [63:0]   product;
  logic [63:0]   mul_result;

  logic          div_done;
  logic [31:0]   div_quot;
  logic [31:0]   div_rem;

  // A 33x33 signed product truncated to 64 bits equals the 64-bit product of
  // the operands sign- or zero-extended to 64 bits, so no wider multiplier.
  always_comb begin
    mul_signed = (op_q == OP_MULT) || (op_q == OP_MADD) || (op_q == OP_MSUB);
    a_ext      = {{32{mul_signed & a_q[31]}}, a_q};
    b_ext      = {{32{mul_signed & b_q[31]}}, b_q};
    product    = a_ext * b_ext;
    case (op_q)
      OP_MADD, OP_MADDU: mul_result = hilo_q + product;
      OP_MSUB, OP_MSUBU: mul_result = hilo_q - product;
      default:           mul_result = product;
    endcase
  end

  multicyc_div #(
    .DIV_BITS (DIV_BITS)
  ) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .is_signed (multicyc_req.op == OP_DIV),
    .dividend  (multicyc_req.reg0),
    .divisor   (multicyc_req.reg1),
    .done      (div_done),
    .quotient  (div_quot),
    .remainder (div_rem)
  );

  // Next-state logic. Flush overrides everything, including an accept in
  // IDLE. The result register is only written when entering DONE, so it
  // keeps showing the last result in every other state.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    result_d  = result_q;
    accept    = 1'b0;
    div_start = 1'b0;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (multicyc_req.is_multicyc) begin
            accept = 1'b1;
            case (multicyc_req.op)
              OP_MTHI: begin
                state_d  = DONE;
                result_d = {multicyc_req.reg0, multicyc_req.hilo[31:0]};
              end
              OP_MTLO: begin
                state_d  = DONE;
                result_d = {multicyc_req.hilo[63:32], multicyc_req.reg0};
              end
              OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
                state_d = MUL;
                count_d = MUL_LOAD;
              end
              OP_DIV, OP_DIVU: begin
                if (multicyc_req.reg1 == 32'd0) begin
                  state_d  = DONE;
                  result_d = {multicyc_req.reg0, 32'hFFFF_FFFF};
                end else begin
                  state_d   = DIV;
                  div_start = 1'b1;
                end
              end
              default: begin
                state_d  = DONE;
                result_d = multicyc_req.hilo;
              end
            endcase
          end
        end
        MUL: begin
          if (count_q == 2'd0) begin
            state_d  = DONE;
            result_d = mul_result;
          end else begin
            count_d = count_q - 2'd1;
          end
        end
        DIV: begin
          if (div_done) begin
            state_d  = DONE;
            result_d = {div_rem, div_quot};
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      count_q  <= 2'd0;
      result_q <= 64'd0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      result_q <= result_d;
    end
  end

  // Operands are frozen at accept so EX may change the request meanwhile.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q   <= OP_MULT;
      a_q    <= 32'd0;
      b_q    <= 32'd0;
      hilo_q <= 64'd0;
    end else if (accept) begin
      op_q   <= multicyc_req.op;
      a_q    <= multicyc_req.reg0;
      b_q    <= multicyc_req.reg1;
      hilo_q <= multicyc_req.hilo;
    end
  end

  // Ready is suppressed combinationally in a flush cycle, even in DONE.
  always_comb begin
    multicyc_resp.ready = (state_q == DONE) && !flush;
    multicyc_resp.hilo  = result_q;
  end

endmodule

// File: tb/tb_multicyc_muldiv.sv
// Directed self-checking bench for multicyc_muldiv (MUL_CYCLES=2, DIV_BITS=32).
module tb_multicyc_muldiv;
  import cpu_defs::*;

  logic           clock = 1'b0;
  logic           resetN;
  logic           flush;
  multicyc_req_t  req;
  multicyc_resp_t resp;

  int compareCount  = 0;
  int mismatchCount = 0;
  int readyCount;

  always #5 clock = ~clock;

  multicyc_muldiv #(
    .MUL_CYCLES (2),
    .DIV_BITS   (32)
  ) dut (
    .clk           (clock),
    .rst           (resetN),
    .multicyc_req  (req),
    .flush         (flush),
    .multicyc_resp (resp)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%016h, expected 0x%016h", tag, observed, expected);
    end
  endtask

  task automatic idleReq();
    req.op          = OP_NOP;
    req.reg0        = 32'd0;
    req.reg1        = 32'd0;
    req.is_multicyc = 1'b0;
    req.hilo        = 64'd0;
  endtask

  // Called at a falling edge with the unit idle. Presents one request, then
  // scribbles over the request bus while the operation runs, and checks the
  // latency (edges from accept to the ready cycle), the result and that
  // ready is a single-cycle pulse.
  task automatic applyStimulus(input string tag, input oper_t op,
                               input logic [31:0] r0, input logic [31:0] r1,
                               input logic [63:0] hi, input logic [63:0] expHilo,
                               input int expLat);
    int lat;
    req.op          = op;
    req.reg0        = r0;
    req.reg1        = r1;
    req.hilo        = hi;
    req.is_multicyc = 1'b1;
    @(posedge clock);
    @(negedge clock);
    req.op   = OP_MTHI;
    req.reg0 = 32'hDEAD_BEEF;
    req.reg1 = 32'h0000_0005;
    req.hilo = ~hi;
    lat = 1;
    while (!resp.ready && lat < 100) begin
      @(negedge clock);
      lat++;
    end
    req.is_multicyc = 1'b0;
    checkOutput($sformatf("%s latency", tag), 64'(lat), 64'(expLat));
    checkOutput($sformatf("%s hilo", tag), resp.hilo, expHilo);
    @(negedge clock);
    checkOutput($sformatf("%s pulse", tag), 64'(resp.ready), 64'd0);
  endtask

  initial begin
    resetN = 1'b0;
    flush  = 1'b0;
    idleReq();
    repeat (3) @(negedge clock);
    checkOutput("reset ready", 64'(resp.ready), 64'd0);
    checkOutput("reset hilo", resp.hilo, 64'd0);
    resetN = 1'b1;
    @(negedge clock);

    // Multiply family
    applyStimulus("MULT -2*3", OP_MULT, 32'hFFFF_FFFE, 32'd3, 64'd0,
                  64'hFFFF_FFFF_FFFF_FFFA, 3);
    applyStimulus("MULTU", OP_MULTU, 32'hFFFF_FFFE, 32'd3, 64'd0,
                  64'h0000_0002_FFFF_FFFA, 3);
    applyStimulus("MADD", OP_MADD, 32'd1, 32'd1, 64'h0000_0000_FFFF_FFFF,
                  64'h0000_0001_0000_0000, 3);
    applyStimulus("MSUB", OP_MSUB, 32'd1, 32'd1, 64'd0,
                  64'hFFFF_FFFF_FFFF_FFFF, 3);
    applyStimulus("MADDU", OP_MADDU, 32'hFFFF_FFFF, 32'd2, 64'd1,
                  64'h0000_0001_FFFF_FFFF, 3);
    applyStimulus("MSUBU", OP_MSUBU, 32'hFFFF_FFFF, 32'd1, 64'h0000_0001_0000_0000,
                  64'h0000_0000_0000_0001, 3);

    // Divide
    applyStimulus("DIV -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 64'd0,
                  64'hFFFF_FFFF_FFFF_FFFD, 33);
    applyStimulus("DIV 7/-2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 64'd0,
                  64'h0000_0001_FFFF_FFFD, 33);
    applyStimulus("DIV min/-1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 64'd0,
                  64'h0000_0000_8000_0000, 33);
    applyStimulus("DIVU min/-1", OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 64'd0,
                  64'h8000_0000_0000_0000, 33);
    applyStimulus("DIVU 100/7", OP_DIVU, 32'd100, 32'd7, 64'd0,
                  64'h0000_0002_0000_000E, 33);
    applyStimulus("DIV by zero", OP_DIV, 32'h0000_1234, 32'd0, 64'h5555_5555_5555_5555,
                  64'h0000_1234_FFFF_FFFF, 1);

    // Moves and the no-change fallback
    applyStimulus("MTLO", OP_MTLO, 32'h0000_ABCD, 32'd0, 64'h1111_2222_3333_4444,
                  64'h1111_2222_0000_ABCD, 1);
    applyStimulus("MTHI", OP_MTHI, 32'h0BAD_F00D, 32'd0, 64'h1111_2222_3333_4444,
                  64'h0BAD_F00D_3333_4444, 1);
    applyStimulus("other op", OP_NOP, 32'h1, 32'h2, 64'hCAFE_0000_BEEF_0001,
                  64'hCAFE_0000_BEEF_0001, 1);

    // Flush at cycle 10 of a divide: no pulse, result unchanged, idle next cycle
    req.op          = OP_DIV;
    req.reg0        = 32'd1000;
    req.reg1        = 32'd3;
    req.hilo        = 64'd0;
    req.is_multicyc = 1'b1;
    @(posedge clock);
    @(negedge clock);
    req.is_multicyc = 1'b0;
    readyCount = 0;
    repeat (9) begin
      @(negedge clock);
      if (resp.ready) readyCount++;
    end
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    checkOutput("flush no ready", 64'(readyCount), 64'd0);
    checkOutput("flush hilo kept", resp.hilo, 64'hCAFE_0000_BEEF_0001);
    applyStimulus("MULT after flush", OP_MULT, 32'd3, 32'd4, 64'd0, 64'd12, 3);
    readyCount = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (resp.ready) readyCount++;
    end
    checkOutput("no stray ready", 64'(readyCount), 64'd0);

    // Flush wins over a request in IDLE
    req.op          = OP_MTHI;
    req.reg0        = 32'h7777_7777;
    req.is_multicyc = 1'b1;
    flush           = 1'b1;
    @(negedge clock);
    req.is_multicyc = 1'b0;
    flush           = 1'b0;
    checkOutput("flush idle no accept", 64'(resp.ready), 64'd0);
    @(negedge clock);
    checkOutput("flush idle still quiet", 64'(resp.ready), 64'd0);
    checkOutput("flush idle hilo", resp.hilo, 64'd12);

    // Flush in DONE forces ready low
    req.op          = OP_MTLO;
    req.reg0        = 32'h0000_0042;
    req.hilo        = 64'd0;
    req.is_multicyc = 1'b1;
    @(posedge clock);
    @(negedge clock);
    req.is_multicyc = 1'b0;
    flush = 1'b1;
    #1;
    checkOutput("flush in DONE", 64'(resp.ready), 64'd0);
    @(negedge clock);
    flush = 1'b0;
    checkOutput("after DONE flush", 64'(resp.ready), 64'd0);

    // Back-to-back MTHI, MTHI: pulses two cycles apart
    req.op          = OP_MTHI;
    req.reg0        = 32'hA1A1_A1A1;
    req.hilo        = 64'h0000_0000_5555_6666;
    req.is_multicyc = 1'b1;
    @(negedge clock);
    checkOutput("b2b first ready", 64'(resp.ready), 64'd1);
    checkOutput("b2b first hilo", resp.hilo, 64'hA1A1_A1A1_5555_6666);
    req.reg0 = 32'hB2B2_B2B2;
    @(negedge clock);
    checkOutput("b2b gap", 64'(resp.ready), 64'd0);
    @(negedge clock);
    req.is_multicyc = 1'b0;
    checkOutput("b2b second ready", 64'(resp.ready), 64'd1);
    checkOutput("b2b second hilo", resp.hilo, 64'hB2B2_B2B2_5555_6666);
    @(negedge clock);
    checkOutput("b2b end", 64'(resp.ready), 64'd0);

    // Asynchronous reset in the middle of a multiply
    req.op          = OP_MULT;
    req.reg0        = 32'd5;
    req.reg1        = 32'd5;
    req.hilo        = 64'd0;
    req.is_multicyc = 1'b1;
    @(posedge clock);
    @(negedge clock);
    req.is_multicyc = 1'b0;
    #2 resetN = 1'b0;
    #1;
    checkOutput("async reset ready", 64'(resp.ready), 64'd0);
    checkOutput("async reset hilo", resp.hilo, 64'd0);
    @(negedge clock);
    resetN = 1'b1;
    readyCount = 0;
    repeat (6) begin
      @(negedge clock);
      if (resp.ready) readyCount++;
    end
    checkOutput("reset discards MUL", 64'(readyCount), 64'd0);
    checkOutput("reset hilo stays 0", resp.hilo, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule

// File: doc/multicyc_muldiv.md
Name: multicyc_muldiv

Overview:
Responder side of the multicyc_req/multicyc_resp interface driven by the EX stage.
It executes all HI/LO-writing operations over one or more cycles: MULT/MULTU, MADD/MADDU, MSUB/MSUBU, DIV/DIVU, MTHI and MTLO.
It returns the new 64-bit {HI,LO} value with a one-cycle ready pulse; EX writes HI/LO and advances on that pulse.
It sits beside the hilo register file inside the execute stage.

Parameters:
MUL_CYCLES, 2, multiply pipeline depth in cycles; legal range 1..4.
DIV_BITS, 32, divider iteration count; fixed at the operand width.

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-low (0 = reset)
multicyc_req  input  multicyc_req_t  fields: op, reg0, reg1 (32 b each), is_multicyc, hilo (64 b, current HI/LO)
flush  input  1  synchronous abort of the in-flight operation (pipeline flush)
multicyc_resp  output  multicyc_resp_t  fields: ready (1 b), hilo (64 b, result {HI,LO})

Behaviour:
- Reset (rst=0, async): state=IDLE, resp.ready=0, resp.hilo=0, all counters and operand registers cleared. Reset mid-operation discards all work.
- States: IDLE, MUL, DIV, DONE.
- Accept rule:
  - The request is sampled in IDLE when is_multicyc=1 and flush=0.
  - op, reg0, reg1 and hilo are latched at accept.
  - Later changes on req are ignored until the FSM returns to IDLE.
- Transitions out of IDLE at accept:
  - MTHI / MTLO -> DONE with result {reg0, hilo[31:0]} / {hilo[63:32], reg0}.
  - MULT family (MULT, MULTU, MADD, MADDU, MSUB, MSUBU) -> MUL; counter := MUL_CYCLES-1.
  - DIV / DIVU with reg1 != 0 -> DIV; counter := DIV_BITS-1.
  - DIV / DIVU with reg1 == 0 -> DONE with result {reg0, 32'hFFFF_FFFF}. Divide by zero raises no exception.
  - Any other op with is_multicyc=1 -> DONE with result = latched hilo (no change).
- MUL state:
  - Product width: 33x33 signed multiply. Operands are sign-extended for signed ops and zero-extended for unsigned ops; product[63:0] is kept.
  - Decrement the counter each cycle; at 0 go to DONE with:
    - MULT/MULTU: product
    - MADD/MADDU: hilo + product
    - MSUB/MSUBU: hilo - product
  - All sums are 64-bit modulo 2^64.
- DIV state:
  - Radix-2 restoring division on magnitudes: |reg0| / |reg1|, one quotient bit per cycle, DIV_BITS cycles.
  - Exit to DONE with sign fix applied:
    - quotient negated iff signed op and the operand signs differ;
    - remainder takes the dividend's sign;
    - result = {rem, quot}.
  - 0x80000000 / -1 (signed) gives {0, 0x80000000}.
- DONE state: resp.ready=1 for exactly one cycle, resp.hilo=result; next state IDLE.
- Latency (accept cycle to ready cycle, inclusive):
  - MTHI/MTLO/divide-by-zero/other: 1
  - MULT family: MUL_CYCLES+1
  - DIV: DIV_BITS+1 = 33
- Back-to-back requests:
  - A request present in the cycle after DONE (FSM in IDLE) is accepted as new.
  - Minimum spacing between ready pulses is 2 cycles.
- resp.hilo holds the last result outside DONE; ready=0 in IDLE, MUL and DIV.
- flush:
  - Any state -> IDLE next cycle. ready is forced 0 in the flush cycle, even in DONE. resp.hilo is unchanged.
  - flush=1 in IDLE with is_multicyc=1: no accept (flush wins).

Decomposition:
- Shared package (cpu_defs): multicyc_req_t, multicyc_resp_t, oper_t (OP_MULT…OP_MTLO), and the local state enum muldiv_state_t.
- One sub-module: multicyc_div, the iterative divider.
  - Inputs: clk, rst, start, is_signed, dividend, divisor.
  - Outputs: done, quotient, remainder.
  - Owns the DIV_BITS counter and the sign fix.
- The multiply pipeline and FSM stay in the top module.

Test Plan:
- MULT reg0=0xFFFFFFFE (-2), reg1=3, MUL_CYCLES=2 -> ready at cycle 3 after accept, hilo=0xFFFFFFFF_FFFFFFFA; MULTU same operands -> hilo=0x00000002_FFFFFFFA.
- MADD hilo=0x00000000_FFFFFFFF, reg0=1, reg1=1 -> hilo=0x00000001_00000000; MSUB hilo=0, reg0=1, reg1=1 -> 0xFFFFFFFF_FFFFFFFF.
- DIV reg0=-7 (0xFFFFFFF9), reg1=2 -> ready 33 cycles after accept, hilo={0xFFFFFFFF, 0xFFFFFFFD}; DIVU 0x80000000/-1 case -> {0, 0x80000000} signed, {0x80000000, 0} unsigned.
- DIV reg1=0, reg0=0x1234 -> ready next cycle, hilo={0x00001234, 0xFFFFFFFF}; MTLO reg0=0xABCD, hilo=0x11112222_33334444 -> 0x11112222_0000ABCD in 1 cycle.
- flush asserted at cycle 10 of a DIV -> no ready pulse, FSM in IDLE next cycle; a following MULT 3x4 completes normally with hilo=12.
- rst driven low mid-MUL, asynchronously between clock edges -> ready=0 and hilo=0 immediately; back-to-back MTHI, MTHI -> ready pulses 2 cycles apart with the correct values.
